// File: rtl/up_counter_ctrl.sv
// -----------------------------------------------------------------------------
// up_counter_ctrl
//   Command sequencer that drives the en/clr inputs of an up_counter.
//   Commands (CLEAR / RUN / RUN_N / STOP) arrive over a valid/ready handshake
//   and are turned into registered, cycle-exact en/clr waveforms. Completion
//   is reported with a one-cycle done pulse; busy is high outside IDLE.
//
//   Optional feature macro: UP_COUNTER_CTRL_WRAP_EN
//     When defined, the count input and wrap output exist. wrap pulses for one
//     cycle each time the counter rolls over from all-ones to zero by counting,
//     never when it returns to zero because of a CLEAR.
//
// Ports
//   clk        in   rising-edge clock, shared with up_counter
//   rst        in   asynchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted when cmd_valid & cmd_ready at a rising edge
//   cmd_op     in   2'b00 CLEAR, 2'b01 RUN, 2'b10 RUN_N, 2'b11 STOP
//   cmd_len    in   RUN_N enable-cycle count, sampled on accept only
//   en         out  to up_counter.en (registered)
//   clr        out  to up_counter.clr (registered)
//   busy       out  state != IDLE
//   done       out  one-cycle completion pulse (registered)
//   count      in   from up_counter.count       [UP_COUNTER_CTRL_WRAP_EN only]
//   wrap       out  counter wrap pulse           [UP_COUNTER_CTRL_WRAP_EN only]
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no command in progress; en=0, clr=0; ready for a command
//   S_CLEAR | clr held high for CLR_CYCLES cycles, then done and IDLE
//   S_RUN   | en high every cycle until STOP or CLEAR; still accepts commands
//   S_RUN_N | en high for the loaded number of cycles, then done and IDLE
// -----------------------------------------------------------------------------
module up_counter_ctrl #(
   parameter int CNT_WIDTH  = 4,
   parameter int RUN_WIDTH  = 8,
   parameter int CLR_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [RUN_WIDTH-1:0] cmd_len,
   output logic                 en,
   output logic                 clr,
   output logic                 busy,
   output logic                 done
`ifdef UP_COUNTER_CTRL_WRAP_EN
   ,
   input  logic [CNT_WIDTH-1:0] count,
   output logic                 wrap
`endif
);

   localparam int CLR_W = $clog2(CLR_CYCLES + 1);
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES);
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(1);
   localparam logic [RUN_WIDTH-1:0] REM_LAST = RUN_WIDTH'(1);

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_RUN_N = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   if (CNT_WIDTH < 1 || RUN_WIDTH < 1 || CLR_CYCLES < 1) begin : g_param_check
      $error("up_counter_ctrl: CNT_WIDTH, RUN_WIDTH and CLR_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_RUN_N = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [RUN_WIDTH-1:0]   rem_q, rem_d;
   logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
   logic                   en_q, en_d;
   logic                   clr_q, clr_d;
   logic                   done_q, done_d;
   logic                   accept;

   // Ready is a pure function of state, forced low while reset is asserted.
   assign cmd_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_RUN));
   assign accept    = cmd_valid & cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         clr_cnt_q <= '0;
         en_q      <= 1'b0;
         clr_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         clr_cnt_q <= clr_cnt_d;
         en_q      <= en_d;
         clr_q     <= clr_d;
         done_q    <= done_d;
      end
   end

   // rem_q counts the en cycles still owed, including the one currently
   // visible on en; clr_cnt_q does the same for clr.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      clr_cnt_d = clr_cnt_q;
      en_d      = 1'b0;
      clr_d     = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE, S_RUN: begin
            en_d = (state_q == S_RUN);
            if (accept) begin
               unique case (cmd_op)
                  OP_CLEAR: begin
                     state_d   = S_CLEAR;
                     clr_cnt_d = CLR_LOAD;
                     clr_d     = 1'b1;
                     en_d      = 1'b0;
                  end
                  OP_RUN: begin
                     state_d = S_RUN;
                     en_d    = 1'b1;
                  end
                  OP_RUN_N: begin
                     rem_d = cmd_len;
                     if (cmd_len == '0) begin
                        // Zero-length run completes immediately without en.
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                     end else begin
                        state_d = S_RUN_N;
                        en_d    = 1'b1;
                     end
                  end
                  OP_STOP: begin
                     // STOP in IDLE is consumed silently.
                     if (state_q == S_RUN) begin
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_CLEAR: begin
            clr_cnt_d = clr_cnt_q - CLR_LAST;
            if (clr_cnt_q == CLR_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               clr_d = 1'b1;
            end
         end

         S_RUN_N: begin
            rem_d = rem_q - REM_LAST;
            if (rem_q == REM_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               en_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign en   = en_q;
   assign clr  = clr_q;
   assign done = done_q;
   assign busy = (state_q != S_IDLE);

`ifdef UP_COUNTER_CTRL_WRAP_EN
   logic [CNT_WIDTH-1:0] count_q;
   logic                 clr_dly_q;
   logic                 wrap_q, wrap_d;

   // A rollover is all-ones last cycle and zero now. clr_dly_q lines up with
   // the cycle in which a clear would have forced the counter to zero, so a
   // CLEAR from all-ones is not mistaken for a wrap.
   assign wrap_d = (count_q == {CNT_WIDTH{1'b1}}) && (count == '0) && !clr_dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         clr_dly_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         count_q   <= count;
         clr_dly_q <= clr_q;
         wrap_q    <= wrap_d;
      end
   end

   assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_up_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_up_counter_ctrl
//   Scoreboard bench for up_counter_ctrl. The driver pushes the expected
//   per-cycle outputs (tagged with the cycle in which they must appear) when
//   it issues a command; a negedge monitor pops and compares them. A small
//   up_counter stand-in is driven by the DUT en/clr so count can be checked.
// -----------------------------------------------------------------------------
module tb_up_counter_ctrl;

   localparam int CLR_N = 3;

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_RUN_N = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_len = 8'd0;
   logic       cmd_ready, en, clr, busy, done;
   logic [3:0] ucnt;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int ecnt  = 0;

   typedef struct {
      int cyc;
      bit en;
      bit clr;
      bit done;
      bit busy;
      bit ready;
      int cnt;
   } exp_t;

   exp_t sb[$];

`ifdef UP_COUNTER_CTRL_WRAP_EN
   logic wrap;
   int   n_wrap = 0;
`endif

   up_counter_ctrl #(
      .CNT_WIDTH (4),
      .RUN_WIDTH (8),
      .CLR_CYCLES(CLR_N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_len  (cmd_len),
      .en       (en),
      .clr      (clr),
      .busy     (busy),
      .done     (done)
`ifdef UP_COUNTER_CTRL_WRAP_EN
      ,
      .count    (ucnt),
      .wrap     (wrap)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // up_counter stand-in: synchronous clear has priority over enable.
   always @(posedge clk or posedge rst) begin
      if (rst)      ucnt <= 4'd0;
      else if (clr) ucnt <= 4'd0;
      else if (en)  ucnt <= ucnt + 4'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic exp_at(input int c, input bit e, input bit cl, input bit d,
                         input bit b, input bit r, input int n);
      exp_t it;
      it.cyc   = c;
      it.en    = e;
      it.clr   = cl;
      it.done  = d;
      it.busy  = b;
      it.ready = r;
      it.cnt   = (n < 0) ? -1 : (n % 16);
      sb.push_back(it);
   endtask

   always @(negedge clk) begin
      exp_t it;
      if (rst === 1'b0) begin
         chk("en_clr_excl", {31'b0, en & clr}, 32'd0);
         chk("done_excl", {31'b0, done & (en | clr)}, 32'd0);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("sb_late", sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         it = sb.pop_front();
         chk("en",    {31'b0, en},        {31'b0, it.en});
         chk("clr",   {31'b0, clr},       {31'b0, it.clr});
         chk("done",  {31'b0, done},      {31'b0, it.done});
         chk("busy",  {31'b0, busy},      {31'b0, it.busy});
         chk("ready", {31'b0, cmd_ready}, {31'b0, it.ready});
         if (it.cnt >= 0) chk("count", {28'b0, ucnt}, it.cnt);
      end
`ifdef UP_COUNTER_CTRL_WRAP_EN
      if (wrap === 1'b1) n_wrap++;
`endif
   end

   // Called just after a rising edge; the command is accepted at the next
   // edge, whose cycle number is returned in t.
   task automatic issue(input logic [1:0] op, input logic [7:0] len, output int t);
      chk("rdy_pre", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      t = cyc + 1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int t;

      rst = 1'b1;
      #1;
      chk("rst_en",    {31'b0, en},        32'd0);
      chk("rst_clr",   {31'b0, clr},       32'd0);
      chk("rst_done",  {31'b0, done},      32'd0);
      chk("rst_busy",  {31'b0, busy},      32'd0);
      chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // RUN_N len=5 from count 0
      issue(OP_RUN_N, 8'd5, t);
      for (int k = 0; k < 5; k++) exp_at(t + k, 1, 0, 0, 1, 0, ecnt + k);
      exp_at(t + 5, 0, 0, 1, 0, 1, ecnt + 5);
      exp_at(t + 6, 0, 0, 0, 0, 1, ecnt + 5);
      ecnt += 5;
      drain();

      // RUN_N len=0: done at once, never en
      issue(OP_RUN_N, 8'd0, t);
      exp_at(t,     0, 0, 1, 0, 1, ecnt);
      exp_at(t + 1, 0, 0, 0, 0, 1, ecnt);
      drain();

      // RUN, STOP 20 cycles later
      issue(OP_RUN, 8'd0, t);
      for (int k = 0; k < 20; k++) exp_at(t + k, 1, 0, 0, 1, 1, ecnt + k);
      exp_at(t + 20, 0, 0, 1, 0, 1, ecnt + 20);
      exp_at(t + 21, 0, 0, 0, 0, 1, ecnt + 20);
      repeat (19) @(posedge clk);
      #1;
      begin
         int t2;
         issue(OP_STOP, 8'd0, t2);
         chk("stop_at", t2, t + 20);
      end
      ecnt += 20;
      drain();

      // CLEAR from count 9, clr held CLR_N cycles
      issue(OP_CLEAR, 8'd0, t);
      for (int k = 0; k < CLR_N; k++) exp_at(t + k, 0, 1, 0, 1, 0, (k == 0) ? ecnt : 0);
      exp_at(t + CLR_N,     0, 0, 1, 0, 1, 0);
      exp_at(t + CLR_N + 1, 0, 0, 0, 0, 1, 0);
      ecnt = 0;
      drain();

      // RUN, RUN again (no change), then RUN_N len=4 from RUN
      issue(OP_RUN, 8'd0, t);
      for (int k = 0; k < 5; k++) exp_at(t + k, 1, 0, 0, 1, 1, ecnt + k);
      for (int k = 5; k < 9; k++) exp_at(t + k, 1, 0, 0, 1, 0, ecnt + k);
      exp_at(t + 9,  0, 0, 1, 0, 1, ecnt + 9);
      exp_at(t + 10, 0, 0, 0, 0, 1, ecnt + 9);
      repeat (2) @(posedge clk);
      #1;
      begin
         int t2;
         issue(OP_RUN, 8'd0, t2);
         @(posedge clk);
         #1;
         issue(OP_RUN_N, 8'd4, t2);
         chk("runn_at", t2, t + 5);
      end
      ecnt += 9;
      drain();

      // RUN, then CLEAR from RUN: single done at end of CLEAR
      issue(OP_RUN, 8'd0, t);
      exp_at(t,     1, 0, 0, 1, 1, ecnt);
      exp_at(t + 1, 1, 0, 0, 1, 1, ecnt + 1);
      for (int k = 2; k < 2 + CLR_N; k++) exp_at(t + k, 0, 1, 0, 1, 0, (k == 2) ? ecnt + 2 : 0);
      exp_at(t + 2 + CLR_N, 0, 0, 1, 0, 1, 0);
      exp_at(t + 3 + CLR_N, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      begin
         int t2;
         issue(OP_CLEAR, 8'd0, t2);
      end
      ecnt = 0;
      drain();

      // STOP in IDLE: no-op, no done
      issue(OP_STOP, 8'd0, t);
      exp_at(t,     0, 0, 0, 0, 1, ecnt);
      exp_at(t + 1, 0, 0, 0, 0, 1, ecnt);
      drain();

      // RUN_N len=200 with cmd_valid held (op RUN), RUN taken in IDLE, then STOP
      chk("rdy_pre", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = OP_RUN_N;
      cmd_len   = 8'd200;
      t = cyc + 1;
      @(posedge clk);
      #1;
      cmd_op = OP_RUN;
      for (int k = 0; k < 200; k++) exp_at(t + k, 1, 0, 0, 1, 0, -1);
      exp_at(t + 200, 0, 0, 1, 0, 1, ecnt + 200);
      exp_at(t + 201, 1, 0, 0, 1, 1, -1);
      exp_at(t + 202, 0, 0, 1, 0, 1, -1);
      exp_at(t + 203, 0, 0, 0, 0, 1, ecnt + 201);
      repeat (201) @(posedge clk);
      #1;
      cmd_op = OP_STOP;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      ecnt += 201;
      drain();

      // Reset 50 cycles into a RUN_N: immediate idle, no done
      issue(OP_RUN_N, 8'd200, t);
      for (int k = 0; k < 49; k++) exp_at(t + k, 1, 0, 0, 1, 0, -1);
      repeat (49) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rstmid_en",    {31'b0, en},        32'd0);
      chk("rstmid_busy",  {31'b0, busy},      32'd0);
      chk("rstmid_done",  {31'b0, done},      32'd0);
      chk("rstmid_ready", {31'b0, cmd_ready}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("rstmid_nodone", {31'b0, done}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst  = 1'b0;
      ecnt = 0;
      for (int k = 0; k < 5; k++) exp_at(cyc + k, 0, 0, 0, 0, 1, 0);
      drain();

`ifdef UP_COUNTER_CTRL_WRAP_EN
      // CLEAR, then RUN_N len=16: exactly one wrap
      issue(OP_CLEAR, 8'd0, t);
      exp_at(t + CLR_N, 0, 0, 1, 0, 1, 0);
      drain();
      n_wrap = 0;
      issue(OP_RUN_N, 8'd16, t);
      exp_at(t + 16, 0, 0, 1, 0, 1, 0);
      exp_at(t + 18, 0, 0, 0, 0, 1, 0);
      drain();
      chk("wrap_count", n_wrap, 1);
      // CLEAR from count 15 must not wrap
      issue(OP_RUN_N, 8'd15, t);
      exp_at(t + 15, 0, 0, 1, 0, 1, 15);
      drain();
      n_wrap = 0;
      issue(OP_CLEAR, 8'd0, t);
      exp_at(t + CLR_N,     0, 0, 1, 0, 1, 0);
      exp_at(t + CLR_N + 2, 0, 0, 0, 0, 1, 0);
      drain();
      chk("wrap_on_clear", n_wrap, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
